// File: rtl/fp32_pkg.sv
// Shared constants and state type for the single-precision normalise/round/pack back end.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 4;
  localparam int WORD_W  = 1 + EXP_W + FRAC_W;
  localparam int BIAS    = 127;
  localparam int EXP_INF = 255;

  // Mantissa layout, MSB first: {carry, hidden, frac, guard, sticky}
  localparam int STICKY_BIT = 0;
  localparam int GUARD_BIT  = 1;
  localparam int HIDDEN_BIT = MANT_W - 2;
  localparam int CARRY_BIT  = MANT_W - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

endpackage

// File: rtl/fp_norm_pack_if.sv
// Handshake bundle between the align/add stage, the normaliser and the result consumer.
interface fp_norm_pack_if;
  import fp32_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EXP_W:0]      in_exp;
  logic [MANT_W-1:0]   in_mant;
  logic                in_special;
  logic [WORD_W-1:0]   in_special_val;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   result;
  logic                overflow;
  logic                inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_special, in_special_val, out_ready,
    input  in_ready, out_valid, result, overflow, inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_special, in_special_val, out_ready,
    output in_ready, out_valid, result, overflow, inexact
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised significand and packing into an IEEE-754 word.
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W:0]    exp_in,
  input  logic [FRAC_W:0]   sig,
  input  logic              guard,
  input  logic              sticky,
  output logic [WORD_W-1:0] word,
  output logic              overflow,
  output logic              inexact
);

  logic                round_up;
  logic [FRAC_W+1:0]   sum;
  logic [EXP_W+1:0]    exp_r;
  logic                hidden_r;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    round_up = guard & (sticky | sig[0]);
    sum      = {1'b0, sig} + {{(FRAC_W+1){1'b0}}, round_up};
    // A carry out of the significand leaves the fraction all-zero and bumps the exponent;
    // for a denormal the carry lands in the hidden bit instead and the exponent stays at 1.
    exp_r    = {1'b0, exp_in} + {{(EXP_W+1){1'b0}}, sum[FRAC_W+1]};
    hidden_r = sum[FRAC_W+1] | sum[FRAC_W];
    overflow = (exp_r >= (EXP_W+2)'(EXP_INF));
    inexact  = guard | sticky | overflow;
    if (overflow)
      word = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else
      word = {sign, (hidden_r ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), sum[FRAC_W-1:0]};
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Sequential normaliser: one shift per clock, then RNE rounding and packing, one op in flight.
module fp_norm_pack
  import fp32_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fp_norm_pack_if.slave bus
);

  localparam logic [EXP_W:0] EXP_ONE = 1;

  state_t              state;
  logic                sign_q;
  logic [EXP_W:0]      exp_q;
  logic [MANT_W-1:0]   mant_q;
  logic [WORD_W-1:0]   result_q;
  logic                ovf_q;
  logic                inx_q;

  logic [WORD_W-1:0]   rnd_word;
  logic                rnd_ovf;
  logic                rnd_inx;

  fp_round_rne u_round (
    .sign     (sign_q),
    .exp_in   (exp_q),
    .sig      (mant_q[HIDDEN_BIT:GUARD_BIT+1]),
    .guard    (mant_q[GUARD_BIT]),
    .sticky   (mant_q[STICKY_BIT]),
    .word     (rnd_word),
    .overflow (rnd_ovf),
    .inexact  (rnd_inx)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.inexact   = inx_q;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.in_sign;
            exp_q  <= bus.in_exp;
            mant_q <= bus.in_mant;
            ovf_q  <= 1'b0;
            inx_q  <= 1'b0;
            if (bus.in_special) begin
              result_q <= bus.in_special_val;
              state    <= DONE;
            end else if (bus.in_mant == '0) begin
              result_q <= '0;
              state    <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (mant_q[CARRY_BIT]) begin
            // Right shift folds the old guard into sticky and the old frac lsb becomes guard.
            mant_q <= {1'b0, mant_q[CARRY_BIT:GUARD_BIT+1],
                       mant_q[GUARD_BIT] | mant_q[STICKY_BIT]};
            exp_q  <= exp_q + 1'b1;
            state  <= ROUND;
          end else if (mant_q[HIDDEN_BIT] || (exp_q <= EXP_ONE)) begin
            state <= ROUND;
          end else begin
            mant_q <= {mant_q[MANT_W-2:0], 1'b0};
            exp_q  <= exp_q - 1'b1;
          end
        end

        ROUND: begin
          result_q <= rnd_word;
          ovf_q    <= rnd_ovf;
          inx_q    <= rnd_inx;
          state    <= DONE;
        end

        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Scoreboard bench for fp_norm_pack: directed operands with hand-derived packed results and latencies.
module tb_fp_norm_pack;
  import fp32_pkg::*;

  typedef struct {
    logic [31:0] word;
    logic        ovf;
    logic        inx;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  fp_norm_pack_if bus ();

  fp_norm_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge E0.
  task automatic drive(input string tag, input logic s, input logic [EXP_W:0] e,
                       input logic [MANT_W-1:0] m, input logic sp, input logic [31:0] sv,
                       input exp_t x);
    sb.push_back(x);
    bus.in_sign        = s;
    bus.in_exp         = e;
    bus.in_mant        = m;
    bus.in_special     = sp;
    bus.in_special_val = sv;
    bus.in_valid       = 1'b1;
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_special = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t x;
    int   k = 0;
    while (!bus.out_valid && k < 64) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    x = sb.pop_front();
    check({tag, "_result"}, bus.result, x.word);
    check({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, x.ovf});
    check({tag, "_inexact"}, {31'd0, bus.inexact}, {31'd0, x.inx});
    check({tag, "_latency"}, 32'(k), 32'(x.lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_result"}, bus.result, x.word);
      check({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_release_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_release_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic s, input logic [EXP_W:0] e,
                     input logic [MANT_W-1:0] m, input logic [31:0] w, input logic o,
                     input logic i, input int lat, input int hold);
    exp_t x;
    x.word = w; x.ovf = o; x.inx = i; x.lat = lat;
    drive(tag, s, e, m, 1'b0, 32'h0, x);
    collect(tag, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t x;
    bus.in_valid = 0; bus.in_sign = 0; bus.in_exp = '0; bus.in_mant = '0;
    bus.in_special = 0; bus.in_special_val = '0; bus.out_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", {30'd0, bus.overflow, bus.inexact}, 32'd0);
    rst = 1'b0;

    run("one_plus_one", 1'b0, 9'(BIAS), 27'h4000000, 32'h40000000, 0, 0, 2, 0);
    run("tie_up",       1'b0, 9'(BIAS), 27'h2000006, 32'h3F800002, 0, 1, 2, 5);
    run("tie_even",     1'b0, 9'(BIAS), 27'h2000002, 32'h3F800000, 0, 1, 2, 0);
    run("cancel23",     1'b0, 9'(BIAS), 27'h0000004, 32'h34000000, 0, 0, 25, 0);
    run("cancel24",     1'b0, 9'(BIAS), 27'h0000002, 32'h33800000, 0, 0, 26, 0);
    run("zero",         1'b0, 9'(BIAS), 27'h0000000, 32'h00000000, 0, 0, 0, 0);
    run("denorm",       1'b0, 9'd1,     27'h1000000, 32'h00400000, 0, 0, 2, 0);
    run("denorm_floor", 1'b0, 9'd5,     27'h0000004, 32'h00000010, 0, 0, 6, 0);
    run("denorm_to_nrm",1'b0, 9'd1,     27'h1FFFFFE, 32'h00800000, 0, 1, 2, 0);
    run("ovf_carry",    1'b0, 9'd254,   27'h4000000, 32'h7F800000, 1, 1, 2, 0);
    run("ovf_round_neg",1'b1, 9'd254,   27'h3FFFFFE, 32'hFF800000, 1, 1, 2, 0);
    run("round_carry",  1'b0, 9'(BIAS), 27'h3FFFFFE, 32'h40000000, 0, 1, 2, 0);
    run("neg_sticky",   1'b1, 9'd130,   27'h2000001, 32'hC1000000, 0, 1, 2, 0);

    x.word = 32'h7FC00000; x.ovf = 0; x.inx = 0; x.lat = 0;
    drive("special_nan", 1'b0, 9'd200, 27'h4000000, 1'b1, 32'h7FC00000, x);
    collect("special_nan", 0);
    x.word = 32'hFF800000;
    drive("special_zero_mant", 1'b1, 9'd1, 27'h0, 1'b1, 32'hFF800000, x);
    collect("special_zero_mant", 0);

    // Reset lands on the 10th SHIFT cycle of a cancellation; the pending expectation is discarded.
    x.word = 32'h34000000; x.ovf = 0; x.inx = 0; x.lat = 25;
    drive("mid_rst", 1'b0, 9'(BIAS), 27'h0000004, 1'b0, 32'h0, x);
    repeat (9) @(posedge clk);
    #1;
    check("mid_rst_busy", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_result", bus.result, 32'h0);
    void'(sb.pop_front());

    run("after_rst", 1'b0, 9'(BIAS), 27'h2000006, 32'h3F800002, 0, 1, 2, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
